// File: rtl/execute_order_dispatcher.sv
// Execute-order dispatcher: buffers exchange fill reports in a FIFO and issues them
// as single-cycle execute-order pulses with a minimum idle gap and a downstream hold.
// The stock-id output doubles as the inventory read index.
module execute_order_dispatcher #(
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned QTY_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_GAP    = 2,
  localparam int unsigned SW        = $clog2(NUM_STOCKS),
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_fill_valid,
  output logic                 o_fill_ready,
  input  logic [SW-1:0]        i_fill_stock_id,
  input  logic [QTY_WIDTH-1:0] i_fill_quantity,
  input  logic                 i_fill_side,
  input  logic                 i_hold,
  output logic                 o_execute_order,
  output logic [SW-1:0]        o_stock_id,
  output logic [QTY_WIDTH-1:0] o_execute_order_quantity,
  output logic                 o_execute_order_side,
  output logic [CW-1:0]        o_fifo_count,
  output logic [15:0]          o_drop_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam int unsigned EW = SW + QTY_WIDTH + 1;
  localparam logic [GW-1:0] GapLoad = GW'(MIN_GAP);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  state_e                 state_q;
  logic [GW-1:0]          gap_q;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [15:0]            drop_q;
  logic                   exec_q;
  logic [SW-1:0]          stock_q;
  logic [QTY_WIDTH-1:0]   qty_q;
  logic                   side_q;

  logic                   accept, push, pop, load_slot;
  logic [SW-1:0]          head_stock;
  logic [QTY_WIDTH-1:0]   head_qty;
  logic                   head_side;

  // Ready reflects the registered count only; a same-cycle pop never frees a slot.
  assign o_fill_ready = (count_q < CW'(FIFO_DEPTH));
  assign accept       = i_fill_valid && o_fill_ready;
  assign push         = accept && (i_fill_quantity != '0);

  // Edges on which the FSM may load a new entry: idle, the last gap edge, or the
  // issue edge itself when no gap is configured.
  assign load_slot = (state_q == StIdle) ||
                     ((state_q == StIssue) && (MIN_GAP == 0)) ||
                     ((state_q == StGap) && (gap_q == GW'(1)));
  assign pop       = load_slot && (count_q != '0) && !i_hold;

  assign {head_stock, head_qty, head_side} = mem_q[rd_ptr_q];

  assign o_execute_order          = exec_q;
  assign o_stock_id               = stock_q;
  assign o_execute_order_quantity = qty_q;
  assign o_execute_order_side     = side_q;
  assign o_fifo_count             = count_q;
  assign o_drop_count             = drop_q;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_fill_stock_id, i_fill_quantity, i_fill_side};
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Saturating count of accepted zero-quantity fills.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drop_q <= '0;
    end else if (accept && (i_fill_quantity == '0) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  // Issue FSM with registered pulse and held order fields.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      exec_q  <= 1'b0;
      stock_q <= '0;
      qty_q   <= '0;
      side_q  <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      if (pop) begin
        exec_q  <= 1'b1;
        stock_q <= head_stock;
        qty_q   <= head_qty;
        side_q  <= head_side;
        state_q <= StIssue;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StIssue: begin
            if (MIN_GAP == 0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
              gap_q   <= GapLoad;
            end
          end
          StGap: begin
            // Hold is ignored here; the gap always runs its full length.
            gap_q <= gap_q - GW'(1);
            if (gap_q == GW'(1)) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
